ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_pc_reg.sv | 38 +++
 rtl/ifu.sv | 121 ++++++++++++
 tb/tb_ifu.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants, widths and state encodings for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } ifu_state_e;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: reset vector, redirect target (word aligned) or sequential +4.
module pc_reg
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Redirect wins over the sequential step when both occur in one cycle.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en_i) begin
      pc_d = align_pc(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry instruction buffer,
// redirect/halt handling with a drop flag for responses that must be discarded.
//
// state    | meaning
// S_REQ    | presenting fetch request for pc
// S_WAIT   | request accepted, awaiting response
// S_HOLD   | instruction buffered, offered to decoder
// S_HALTED | fetch stopped until reset
module ifu
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt,
  output logic              halted
);

  ifu_state_e        state_q;
  logic              drop_q;
  logic              halt_pend_q;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   inst_pc_q;
  logic [PC_W-1:0]   pc;
  logic              redirect_en;
  logic              advance;

  assign redirect_en = redirect_valid && (state_q != S_HALTED);
  assign advance     = (state_q == S_HOLD) && inst_ready && !halt;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .redirect_en_i(redirect_en),
    .redirect_pc_i(redirect_pc),
    .advance_i    (advance),
    .pc_o         (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      // A request still in flight across reset must have its response discarded.
      drop_q      <= (drop_q || (state_q == S_WAIT)) && !imem_rsp_valid;
      halt_pend_q <= 1'b0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (drop_q && imem_rsp_valid) begin
            drop_q <= 1'b0;
          end
          if (halt) begin
            state_q <= S_HALTED;
          end else if (imem_req_ready) begin
            state_q <= S_WAIT;
            if (redirect_valid) begin
              drop_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop_q <= 1'b0;
            if (halt_pend_q || halt) begin
              halt_pend_q <= 1'b0;
              state_q     <= S_HALTED;
            end else if (drop_q || redirect_valid) begin
              state_q <= S_REQ;
            end else begin
              inst_q    <= imem_rsp_data;
              inst_pc_q <= pc;
              state_q   <= S_HOLD;
            end
          end else if (redirect_valid || halt) begin
            drop_q <= 1'b1;
            if (halt) begin
              halt_pend_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (halt) begin
            state_q <= S_HALTED;
          end else if (inst_ready || redirect_valid) begin
            state_q <= S_REQ;
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && !halt && !rst;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == S_HOLD) && !rst;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign halted         = (state_q == S_HALTED) && !rst;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized traffic against a
// program-order model (expected next fetch/delivery address) and a latency-configurable memory.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        halted;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  ifu dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_insts = 0;

  // memory model
  bit          pend = 0;
  logic [63:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          lat_cfg = 1;

  // program-order model
  logic [63:0] exp_next = RST_PC;
  bit          hold_chk = 0;
  logic [31:0] hold_inst;
  logic [63:0] hold_pc;
  bit          prev_rst = 1;

  // per-cycle samples
  bit          s_req_fire, s_req_valid, s_inst_fire, s_inst_valid, s_rsp;
  logic [63:0] s_req_addr, s_inst_pc;
  logic [31:0] s_inst;

  function automatic logic [31:0] memfn(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0F1E_2D3C;
  endfunction

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit irdy, input bit rv,
                      input logic [63:0] rpc, input bit h);
    int l;
    @(posedge clk);
    #1;
    s_rsp = 0;
    if (pend) begin
      if (pend_cnt == 0) begin
        s_rsp = 1;
        pend  = 0;
      end else begin
        pend_cnt--;
      end
    end
    imem_rsp_valid = s_rsp;
    imem_rsp_data  = s_rsp ? memfn(pend_addr) : $urandom;
    rst            = r;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    #1;
    if (hold_chk) begin
      chk1("hold_valid", inst_valid, 1'b1);
      chk64("hold_inst", {32'd0, inst}, {32'd0, hold_inst});
      chk64("hold_pc", inst_pc, hold_pc);
    end
    hold_chk     = 0;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_req_fire   = imem_req_valid && rdy;
    s_inst_valid = inst_valid;
    s_inst_fire  = inst_valid && irdy;
    s_inst       = inst;
    s_inst_pc    = inst_pc;
    if (r) begin
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      if (prev_rst) begin
        chk64("rst_inst", {32'd0, inst}, 64'd0);
        chk64("rst_inst_pc", inst_pc, 64'd0);
      end
      exp_next = RST_PC;
    end else begin
      if (imem_req_valid) begin
        chk64("req_addr", imem_req_addr, exp_next);
      end
      if (s_req_fire) begin
        chk1("one_outstanding", pend, 1'b0);
        l         = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
        pend      = 1;
        pend_addr = imem_req_addr;
        pend_cnt  = l - 1;
      end
      if (s_inst_fire) begin
        chk64("inst_pc", inst_pc, exp_next);
        chk64("inst_data", {32'd0, inst}, {32'd0, memfn(exp_next)});
        n_insts++;
        exp_next = exp_next + 64'd4;
      end
      if (inst_valid && !irdy && !rv && !h) begin
        hold_chk  = 1;
        hold_inst = inst;
        hold_pc   = inst_pc;
      end
      if (rv) begin
        exp_next = {rpc[63:2], 2'b00};
      end
    end
    prev_rst = r;
  endtask

  // what: 0 req accepted, 1 inst_valid, 2 inst handshake, 3 req_valid
  task automatic run_until(input int what, input bit rdy, input bit irdy, input int budget,
                           input string tag);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step(0, rdy, irdy, 0, 64'd0, 0);
      case (what)
        0:       found = s_req_fire;
        1:       found = s_inst_valid;
        2:       found = s_inst_fire;
        3:       found = s_req_valid;
        default: found = 0;
      endcase
    end
    chk1(tag, found, 1'b1);
  endtask

  initial begin
    int          vcnt;
    int          vcyc[3];
    logic [63:0] vpc[3];
    logic [31:0] held_inst;
    logic [63:0] held_pc;
    bit          found;
    int          base;

    rst = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = '0; halt = 0;

    // reset release, zero-wait memory, steady consumption
    lat_cfg = 1;
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 64'd0, 0);
    vcnt = 0;
    for (int c = 0; c < 9; c++) begin
      step(0, 1, 1, 0, 64'd0, 0);
      if (c == 0) chk1("first_req_after_rst", s_req_fire, 1'b1);
      if (s_inst_valid && vcnt < 3) begin
        vcyc[vcnt] = c;
        vpc[vcnt]  = s_inst_pc;
        vcnt++;
      end
    end
    chk64("steady_count", 64'(vcnt), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk64("steady_cycle", 64'(vcyc[k]), 64'(2 + 3 * k));
      chk64("steady_pc", vpc[k], RST_PC + 64'(4 * k));
    end

    // memory not ready for 5 cycles
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 64'd0, 0);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 1, 0, 64'd0, 0);
      chk1("stall_req_valid", s_req_valid, 1'b1);
      chk64("stall_addr", s_req_addr, RST_PC);
    end
    step(0, 1, 1, 0, 64'd0, 0);
    chk1("stall_accept", s_req_fire, 1'b1);
    run_until(2, 1, 1, 10, "stall_drain");

    // redirect while waiting for a slow response
    lat_cfg = 3;
    run_until(0, 1, 1, 10, "redir_wait_accept");
    step(0, 1, 1, 1, 64'h8000_0102, 0);
    run_until(1, 1, 1, 20, "redir_wait_inst");
    chk64("redir_wait_pc", s_inst_pc, 64'h8000_0100);
    chk64("redir_wait_data", {32'd0, s_inst}, {32'd0, memfn(64'h8000_0100)});

    // decoder stall in HOLD then redirect with handshake
    lat_cfg = 1;
    run_until(1, 1, 0, 20, "hold_reach");
    held_inst = s_inst;
    held_pc   = s_inst_pc;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 64'd0, 0);
      chk64("hold_stable_pc", s_inst_pc, held_pc);
      chk64("hold_stable_inst", {32'd0, s_inst}, {32'd0, held_inst});
    end
    step(0, 1, 1, 1, 64'h8000_0040, 0);
    chk1("hold_redir_handshake", s_inst_fire, 1'b1);
    run_until(3, 1, 1, 5, "hold_redir_req");
    chk64("hold_redir_addr", s_req_addr, 64'h8000_0040);

    // pc wrap at the top of the address space
    step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_until(2, 1, 1, 20, "wrap_inst0");
    chk64("wrap_pc0", s_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    run_until(2, 1, 1, 20, "wrap_inst1");
    chk64("wrap_pc1", s_inst_pc, 64'h0);

    // randomized traffic
    lat_cfg = 0;
    base = n_insts;
    for (int i = 0; i < 1500; i++) begin
      bit          rv;
      logic [63:0] rpc;
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                        : 64'h8000_0000 + 64'($urandom_range(0, 1023));
      step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rv, rpc, 0);
    end
    chk1("random_progress", (n_insts - base) > 100, 1'b1);

    // halt while waiting for a response
    lat_cfg = 3;
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 64'd0, 0);
    run_until(0, 1, 1, 10, "halt_accept");
    step(0, 1, 1, 0, 64'd0, 1);
    chk1("halt_wait_inst_valid", s_inst_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(0, 1, 1, 0, 64'd0, 0);
      chk1("halt_pend_inst_valid", s_inst_valid, 1'b0);
      chk1("halt_pend_halted", halted, 1'b0);
      found = s_rsp;
    end
    chk1("halt_rsp_seen", found, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, i[0], 64'h8000_0200, 0);
      chk1("halted_flag", halted, 1'b1);
      chk1("halted_no_req", s_req_valid, 1'b0);
      chk1("halted_no_inst", s_inst_valid, 1'b0);
    end

    // reset during WAIT, late response lands right after reset
    lat_cfg = 1;
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 64'd0, 0);
    run_until(2, 1, 1, 10, "rstwait_first");
    lat_cfg = 3;
    run_until(0, 1, 1, 10, "rstwait_accept");
    chk64("rstwait_pending_addr", s_req_addr, RST_PC + 64'd4);
    lat_cfg = 1;
    step(1, 1, 1, 0, 64'd0, 0);
    step(1, 1, 1, 0, 64'd0, 0);
    step(0, 1, 1, 0, 64'd0, 0);
    chk1("rstwait_late_rsp", s_rsp, 1'b1);
    chk1("rstwait_new_req", s_req_fire, 1'b1);
    run_until(1, 1, 1, 10, "rstwait_inst");
    chk64("rstwait_pc", s_inst_pc, RST_PC);
    chk64("rstwait_data", {32'd0, s_inst}, {32'd0, memfn(RST_PC)});
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 64'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
